// File: rtl/banco_pkg.sv
// Shared address map constants and the writable-register decode helper
// used by the register bank.
package banco_pkg;

  localparam int ADDR_ZERO    = 0;
  localparam int ADDR_REF     = 1;
  localparam int ADDR_POT     = 2;
  localparam int ADDR_RW_BASE = 3;

  typedef struct packed {
    logic        valid;
    logic [31:0] idx;
  } rw_map_t;

  // Translate a bus address to a writable-register index.
  // valid is set only for addresses inside the writable window.
  function automatic rw_map_t rw_map(
    input logic [31:0] addr,
    input int          nrw
  );
    rw_map_t m;
    m.valid = (addr >= 32'(ADDR_RW_BASE)) &&
              (addr < 32'(ADDR_RW_BASE + nrw));
    m.idx   = m.valid ? addr - 32'(ADDR_RW_BASE) : '0;
    return m;
  endfunction

endpackage

// File: rtl/banco_regs_param_reg_en.sv
// DW-bit storage register with load enable and asynchronous
// active-high clear.
module reg_en #(
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/banco_regs_param.sv
// Parameterised register bank: two registered read ports with write
// forwarding, external REF/POT operands and a double-buffered PWM value.
import banco_pkg::*;

module banco_regs_param #(
  parameter int DW      = 18,
  parameter int AW      = 4,
  parameter int NRW     = 8,
  parameter int PWM_IDX = NRW - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          WtReg,
  input  logic [AW-1:0] RdAddrs,
  input  logic [DW-1:0] WrDat,
  input  logic [AW-1:0] RsAddrs,
  input  logic [AW-1:0] RtAddrs,
  input  logic [DW-1:0] REF,
  input  logic [DW-1:0] POT,
  input  logic          Commit,
  output logic [DW-1:0] OperaA,
  output logic [DW-1:0] OperaB,
  output logic [DW-1:0] PWM,
  output logic          WrErr
);

  logic [DW-1:0] r [NRW];
  logic [NRW-1:0] we;
  rw_map_t        wmap;
  logic           wr_ok;

  always_comb begin
    wmap  = rw_map(32'(RdAddrs), NRW);
    wr_ok = WtReg && wmap.valid;
  end

  for (genvar i = 0; i < NRW; i++) begin : g_rw
    assign we[i] = wr_ok && (wmap.idx == 32'(i));

    reg_en #(.DW(DW)) u_reg (
      .clk (clk),
      .rst (rst),
      .en  (we[i]),
      .d   (WrDat),
      .q   (r[i])
    );
  end

  // Port 0 serves RtAddrs (OperaA), port 1 serves RsAddrs (OperaB).
  logic [AW-1:0] raddr [2];
  logic [DW-1:0] rdat  [2];
  rw_map_t       rmap  [2];

  assign raddr[0] = RtAddrs;
  assign raddr[1] = RsAddrs;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdat[p] = '0;
      rmap[p] = rw_map(32'(raddr[p]), NRW);
      if (wr_ok && (raddr[p] == RdAddrs)) begin
        rdat[p] = WrDat;
      end else if (rmap[p].valid) begin
        for (int i = 0; i < NRW; i++) begin
          if (rmap[p].idx == 32'(i)) rdat[p] = r[i];
        end
      end else if (raddr[p] == AW'(ADDR_REF)) begin
        rdat[p] = REF;
      end else if (raddr[p] == AW'(ADDR_POT)) begin
        rdat[p] = POT;
      end
    end
  end

  logic [DW-1:0] pwm_src;

  assign pwm_src = we[PWM_IDX] ? WrDat : r[PWM_IDX];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OperaA <= '0;
      OperaB <= '0;
      PWM    <= '0;
      WrErr  <= 1'b0;
    end else begin
      OperaA <= rdat[0];
      OperaB <= rdat[1];
      WrErr  <= WtReg && !wmap.valid;
      if (Commit) PWM <= pwm_src;
    end
  end

endmodule

// File: tb/tb_banco_regs_param.sv
// Directed checks on the default bank and randomized regression of a
// wide bank against a behavioural model.
module tb_banco_regs_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_we, a_commit, a_err;
  logic [3:0]  a_wa, a_ra, a_rb;
  logic [17:0] a_wd, a_ref, a_pot, a_oa, a_ob, a_pwm;

  banco_regs_param #(.DW(18), .AW(4), .NRW(8)) dut_a (
    .clk(clk), .rst(a_rst), .WtReg(a_we), .RdAddrs(a_wa),
    .WrDat(a_wd), .RsAddrs(a_rb), .RtAddrs(a_ra), .REF(a_ref),
    .POT(a_pot), .Commit(a_commit), .OperaA(a_oa), .OperaB(a_ob),
    .PWM(a_pwm), .WrErr(a_err)
  );

  logic        b_rst, b_we, b_commit, b_err;
  logic [4:0]  b_wa, b_ra, b_rb;
  logic [23:0] b_wd, b_ref, b_pot, b_oa, b_ob, b_pwm;

  banco_regs_param #(.DW(24), .AW(5), .NRW(20)) dut_b (
    .clk(clk), .rst(b_rst), .WtReg(b_we), .RdAddrs(b_wa),
    .WrDat(b_wd), .RsAddrs(b_rb), .RtAddrs(b_ra), .REF(b_ref),
    .POT(b_pot), .Commit(b_commit), .OperaA(b_oa), .OperaB(b_ob),
    .PWM(b_pwm), .WrErr(b_err)
  );

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of the wide bank
  logic [23:0] mr [20];
  logic [23:0] ea, eb, ep, pa, pb, pp;
  logic        ee, pe;
  bit          chk_on = 1'b0;

  function automatic bit legal(input logic [4:0] a);
    return (a >= 5'd3) && (a <= 5'd22);
  endfunction

  function automatic logic [23:0] mread(input logic [4:0] a);
    if (b_we && legal(b_wa) && b_wa == a) return b_wd;
    if (a == 5'd1) return b_ref;
    if (a == 5'd2) return b_pot;
    if (legal(a)) return mr[int'(a) - 3];
    return '0;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("B.OperaA", 32'(b_oa), 32'(ea));
      chk("B.OperaB", 32'(b_ob), 32'(eb));
      chk("B.PWM", 32'(b_pwm), 32'(ep));
      chk("B.WrErr", 32'(b_err), 32'(ee));
    end
  end

  initial begin
    logic [17:0] ex;
    a_rst = 1'b1; a_we = 1'b0; a_commit = 1'b0;
    a_wa = '0; a_ra = '0; a_rb = '0; a_wd = '0;
    a_ref = 18'h00ABC; a_pot = 18'h3FFFF;
    b_rst = 1'b1; b_we = 1'b0; b_commit = 1'b0;
    b_wa = '0; b_ra = '0; b_rb = '0; b_wd = '0;
    b_ref = '0; b_pot = '0;
    ea = '0; eb = '0; ep = '0; ee = 1'b0;
    for (int i = 0; i < 20; i++) mr[i] = '0;

    step();
    chk("rst.OperaA", 32'(a_oa), 32'h0);
    chk("rst.OperaB", 32'(a_ob), 32'h0);
    chk("rst.PWM", 32'(a_pwm), 32'h0);
    chk("rst.WrErr", 32'(a_err), 32'h0);
    a_rst = 1'b0;

    // address map sweep
    for (int a = 0; a < 16; a++) begin
      a_ra = 4'(a);
      a_rb = 4'(15 - a);
      step();
      ex = (a == 1) ? 18'h00ABC : (a == 2) ? 18'h3FFFF : 18'h0;
      chk("map.OperaA", 32'(a_oa), 32'(ex));
      ex = (a == 14) ? 18'h00ABC : (a == 13) ? 18'h3FFFF : 18'h0;
      chk("map.OperaB", 32'(a_ob), 32'(ex));
    end

    // write with same-cycle forwarding on both ports
    a_we = 1'b1; a_wa = 4'd5; a_wd = 18'h12345;
    a_ra = 4'd5; a_rb = 4'd5;
    step();
    chk("fwd.OperaA", 32'(a_oa), 32'h12345);
    chk("fwd.OperaB", 32'(a_ob), 32'h12345);
    chk("fwd.WrErr", 32'(a_err), 32'h0);
    a_we = 1'b0; a_ra = 4'd0;
    step();
    chk("rd5.OperaB", 32'(a_ob), 32'h12345);

    // illegal writes pulse WrErr for one cycle
    for (int k = 0; k < 2; k++) begin
      a_we = 1'b1; a_wa = (k == 0) ? 4'd1 : 4'd12; a_wd = 18'h3FFFF;
      step();
      chk("err.pulse", 32'(a_err), 32'h1);
      a_we = 1'b0;
      step();
      chk("err.clear", 32'(a_err), 32'h0);
    end
    for (int a = 3; a < 11; a++) begin
      a_ra = 4'(a); a_rb = 4'(a);
      step();
      ex = (a == 5) ? 18'h12345 : 18'h0;
      chk("keep.OperaA", 32'(a_oa), 32'(ex));
      chk("keep.OperaB", 32'(a_ob), 32'(ex));
    end

    // PWM double buffering
    a_we = 1'b1; a_wa = 4'd10; a_wd = 18'h00100;
    step();
    chk("pwm.hold0", 32'(a_pwm), 32'h0);
    a_we = 1'b0; a_commit = 1'b1;
    step();
    chk("pwm.commit", 32'(a_pwm), 32'h00100);
    a_we = 1'b1; a_wd = 18'h00200;
    step();
    chk("pwm.fwd", 32'(a_pwm), 32'h00200);
    a_commit = 1'b0; a_wd = 18'h00300; a_ra = 4'd5;
    step();
    chk("pwm.hold", 32'(a_pwm), 32'h00200);
    a_we = 1'b0;
    step();

    // asynchronous reset mid-cycle
    #3;
    a_rst = 1'b1;
    #1;
    chk("arst.OperaA", 32'(a_oa), 32'h0);
    chk("arst.PWM", 32'(a_pwm), 32'h0);
    chk("arst.OperaB", 32'(a_ob), 32'h0);
    step();
    a_rst = 1'b0; a_ra = 4'd5; a_rb = 4'd10;
    step();
    chk("arst.r5", 32'(a_oa), 32'h0);
    chk("arst.r10", 32'(a_ob), 32'h0);

    // randomized regression on the wide bank
    b_rst = 1'b0;
    chk_on = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        b_rst = 1'b1;
        for (int i = 0; i < 20; i++) mr[i] = '0;
        ea = '0; eb = '0; ep = '0; ee = 1'b0;
        step();
        b_rst = 1'b0;
      end
      b_we     = ($urandom_range(0, 1) == 1);
      b_wa     = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) b_wa = 5'd22;
      b_wd     = 24'($urandom);
      b_ra     = ($urandom_range(0, 3) == 0) ? b_wa
                                             : 5'($urandom_range(0, 31));
      b_rb     = ($urandom_range(0, 3) == 0) ? b_ra
                                             : 5'($urandom_range(0, 31));
      b_ref    = 24'($urandom);
      b_pot    = 24'($urandom);
      b_commit = ($urandom_range(0, 3) == 0);
      pa = mread(b_ra);
      pb = mread(b_rb);
      pe = b_we && !legal(b_wa);
      pp = !b_commit ? ep
         : (b_we && b_wa == 5'd22) ? b_wd : mr[19];
      if (b_we && legal(b_wa)) mr[int'(b_wa) - 3] = b_wd;
      step();
      ea = pa; eb = pb; ep = pp; ee = pe;
    end
    @(negedge clk);
    #1;
    chk_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule
